// File: rtl/segment_r_responder_pkg.sv
// Shared definitions for the read-only segment responder:
// FSM state encoding, output-buffer entry layout and a ceil(log2) helper.
package segment_r_responder_pkg;

    // Widest data token the output buffer can carry; DATA_W must not exceed it.
    localparam int SEGR_DATA_W = 8;

    typedef enum logic [1:0] {
        SEGR_RUN   = 2'd0,
        SEGR_DRAIN = 2'd1,
        SEGR_DONE  = 2'd2
    } segr_state_t;

    typedef struct packed {
        logic [SEGR_DATA_W-1:0] data;
        logic                   e;
    } segr_entry_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/segment_r_responder_segr_out_fifo.sv
// Two-entry {data, e} output buffer for the segment responder.
// Reports its occupancy so the parent can add its in-flight read when
// deciding whether the address stream must be back-pressured.
module segr_out_fifo
    import segment_r_responder_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_push,
    input  segr_entry_t i_pushEntry,
    input  logic        i_pop,
    output segr_entry_t o_headEntry,
    output logic [1:0]  o_count
);

    segr_entry_t r_slots [2];
    logic        r_wrPtr;
    logic        r_rdPtr;
    logic [1:0]  r_count;

    // Pointer and occupancy bookkeeping; a push and pop together leave the count unchanged.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_slots[r_wrPtr] <= i_pushEntry;
                r_wrPtr          <= ~r_wrPtr;
            end
            if (i_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_headEntry = r_slots[r_rdPtr];
    assign o_count     = r_count;

endmodule

// File: rtl/segment_r_responder.sv
// Read-only segment responder: turns a stream of address tokens into a
// stream of table words, one per address, in order. An end-of-stream
// address token is answered with an end-of-stream data token, after which
// the block parks until reset.
// Optional feature macro: SEGR_BOUNDS_CHECK_EN (out-of-range addresses
// return 0 and raise a sticky err instead of wrapping).
module segment_r_responder
    import segment_r_responder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = SEGR_DATA_W,
    parameter int DEPTH  = 256
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         addr_d,
    input  logic                      addr_e,
    input  logic                      addr_v,
    output logic                      addr_b,
    output logic [DATA_W-1:0]         data_d,
    output logic                      data_e,
    output logic                      data_v,
    input  logic                      data_b,
    input  logic                      init_we,
    input  logic [clog2(DEPTH)-1:0]   init_addr,
    input  logic [DATA_W-1:0]         init_data,
    output logic                      err
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_W-1:0] r_table [DEPTH];
    logic [DATA_W-1:0] r_rdWord;
    segr_state_t       r_state;
    logic              r_pend;
    logic              r_pendEnd;
    logic              r_pendZero;

    logic              w_addrFire;
    logic              w_dataFire;
    logic              w_dataValid;
    logic              w_oob;
    logic [AW-1:0]     w_index;
    logic [1:0]        w_count;
    logic [1:0]        w_occupancy;
    logic              w_fifoPush;
    logic              w_fifoPop;
    segr_entry_t       w_fifoHead;
    segr_entry_t       w_pendEntry;
    segr_entry_t       w_head;

`ifdef SEGR_BOUNDS_CHECK_EN
    logic r_err;

    assign w_oob   = (addr_d >= ADDR_W'(DEPTH));
    assign w_index = addr_d[AW-1:0];
    assign err     = r_err;

    // Sticky flag: any accepted data address beyond the table end is remembered until reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_addrFire && !addr_e && w_oob) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unusedAddrHi;

    assign w_oob          = 1'b0;
    assign w_index        = addr_d[AW-1:0];
    assign err            = 1'b0;
    assign w_unusedAddrHi = ^addr_d[ADDR_W-1:AW];
`endif

    // The in-flight read counts against the two buffer slots so a result always has room to land.
    assign w_occupancy = w_count + {1'b0, r_pend};
    assign addr_b      = !reset || (r_state != SEGR_RUN) || (w_occupancy >= 2'd2);
    assign w_addrFire  = addr_v && !addr_b;

    // The read result bypasses the buffer when nothing older is waiting, giving one-cycle latency.
    assign w_pendEntry.data = (r_pendEnd || r_pendZero) ? '0 : SEGR_DATA_W'(r_rdWord);
    assign w_pendEntry.e    = r_pendEnd;
    assign w_head           = (w_count != 2'd0) ? w_fifoHead : w_pendEntry;

    assign w_dataValid = reset && (r_state != SEGR_DONE) && ((w_count != 2'd0) || r_pend);
    assign w_dataFire  = w_dataValid && !data_b;
    assign w_fifoPop   = w_dataFire && (w_count != 2'd0);
    assign w_fifoPush  = r_pend && !(w_dataFire && (w_count == 2'd0));

    assign data_v = w_dataValid;
    assign data_d = w_dataValid ? DATA_W'(w_head.data) : '0;
    assign data_e = w_dataValid && w_head.e;

    // Table storage: loads may land at any time, reads return the pre-write word on a same-index collision.
    always_ff @(posedge clock) begin
        if (init_we) begin
            r_table[init_addr] <= init_data;
        end
        if (w_addrFire && !addr_e) begin
            r_rdWord <= r_table[w_index];
        end
    end

    // Control FSM plus the single-stage read pipeline tags that travel with each accepted token.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= SEGR_RUN;
            r_pend     <= 1'b0;
            r_pendEnd  <= 1'b0;
            r_pendZero <= 1'b0;
        end else begin
            r_pend     <= w_addrFire;
            r_pendEnd  <= w_addrFire && addr_e;
            r_pendZero <= w_addrFire && w_oob;
            case (r_state)
                SEGR_RUN: begin
                    if (w_addrFire && addr_e) begin
                        r_state <= SEGR_DRAIN;
                    end
                end
                SEGR_DRAIN: begin
                    if (w_dataFire && w_head.e) begin
                        r_state <= SEGR_DONE;
                    end
                end
                SEGR_DONE: begin
                    r_state <= SEGR_DONE;
                end
                default: begin
                    r_state <= SEGR_RUN;
                end
            endcase
        end
    end

    segr_out_fifo uOutFifo (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_push      (w_fifoPush),
        .i_pushEntry (w_pendEntry),
        .i_pop       (w_fifoPop),
        .o_headEntry (w_fifoHead),
        .o_count     (w_count)
    );

endmodule

// File: tb/tb_segment_r_responder.sv
// Self-checking bench for segment_r_responder. Expected tokens are queued
// when an address is accepted and compared when the DUT emits a token.
// Honours SEGR_BOUNDS_CHECK_EN for the out-of-range expectations.
module tb_segment_r_responder;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;

    typedef struct packed {
        logic [7:0] data;
        logic       e;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] addr_d = '0;
    logic              addr_e = 1'b0;
    logic              addr_v = 1'b0;
    logic              addr_b;
    logic [DATA_W-1:0] data_d;
    logic              data_e;
    logic              data_v;
    logic              data_b = 1'b0;
    logic              init_we = 1'b0;
    logic [7:0]        init_addr = '0;
    logic [DATA_W-1:0] init_data = '0;
    logic              err;

    exp_t       expQ [$];
    exp_t       monExp;
    logic [7:0] tblModel [DEPTH];
    int         vectors = 0;
    int         miscompares = 0;
    int         outCount = 0;

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    segment_r_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .addr_d    (addr_d),
        .addr_e    (addr_e),
        .addr_v    (addr_v),
        .addr_b    (addr_b),
        .data_d    (data_d),
        .data_e    (data_e),
        .data_v    (data_v),
        .data_b    (data_b),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .err       (err)
    );

    // Scoreboard: every transferred data token must match the oldest queued expectation.
    always @(negedge clock) begin
        if (reset && data_v && !data_b) begin
            outCount++;
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_token got d=%h e=%b required no token", data_d, data_e);
            end else begin
                monExp = expQ.pop_front();
                if (data_d !== monExp.data || data_e !== monExp.e) begin
                    miscompares++;
                    $display("[TB] FAIL token got d=%h e=%b required d=%h e=%b",
                             data_d, data_e, monExp.data, monExp.e);
                end
            end
        end
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] expWord(input logic [31:0] a);
`ifdef SEGR_BOUNDS_CHECK_EN
        if (a >= 32'(DEPTH)) return 8'h00;
`endif
        return tblModel[a[7:0]];
    endfunction

    // Offer one address token and wait for it to be accepted; queues its expected answer.
    task automatic applyStimulus(input logic [31:0] a, input logic e, output int waits);
        bit accepted;
        accepted = 0;
        waits    = 0;
        addr_d   = a;
        addr_e   = e;
        addr_v   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!addr_b) begin
                if (e) expQ.push_back('{data: 8'h00, e: 1'b1});
                else   expQ.push_back('{data: expWord(a), e: 1'b0});
                accepted = 1;
                @(posedge clock); #1;
                break;
            end
            @(posedge clock); #1;
            waits++;
        end
        addr_v = 1'b0;
        addr_e = 1'b0;
        if (!accepted) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout addr=%0d addr_b=%b required acceptance", a, addr_b);
        end
    endtask

    task automatic drainWait(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (expQ.size() == 0) break;
        end
        @(posedge clock); #1;
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain pending=%0d required 0", expQ.size());
        end
    endtask

    task automatic loadTable();
        for (int i = 0; i < DEPTH; i++) begin
            init_we     = 1'b1;
            init_addr   = 8'(i);
            init_data   = 8'(i) ^ 8'h5A;
            tblModel[i] = 8'(i) ^ 8'h5A;
            @(posedge clock); #1;
        end
        init_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        vectors += 5;
        if (addr_b !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_addr_b got %b required 1", addr_b); end
        if (data_v !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_data_v got %b required 0", data_v); end
        if (data_e !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_data_e got %b required 0", data_e); end
        if (data_d !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data_d got %h required 00", data_d); end
        if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got %b required 0", err); end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        vectors += 2;
        if (addr_b !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_addr_b got %b required 0", addr_b); end
        if (data_v !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_data_v got %b required 0", data_v); end
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        int w;
        data_b = 1'b0;
        applyStimulus(32'd0, 1'b0, w);
        @(negedge clock);
        vectors++;
        if (data_v !== 1'b1 || data_d !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL latency_addr0 got v=%b d=%h required v=1 d=5a", data_v, data_d);
        end
        @(posedge clock); #1;
        applyStimulus(32'd1, 1'b0, w);
        vectors++;
        if (w != 0) begin miscompares++; $display("[TB] FAIL b2b_addr1 waits=%0d required 0", w); end
        applyStimulus(32'd255, 1'b0, w);
        vectors++;
        if (w != 0) begin miscompares++; $display("[TB] FAIL b2b_addr255 waits=%0d required 0", w); end
        @(negedge clock);
        vectors++;
        if (data_v !== 1'b1 || data_d !== 8'hA5) begin
            miscompares++;
            $display("[TB] FAIL latency_addr255 got v=%b d=%h required v=1 d=a5", data_v, data_d);
        end
        @(posedge clock); #1;
        drainWait(10);
    endtask

    task automatic test_backpressure();
        logic [31:0] addrs [4];
        int idx;
        int base;
        bit acc;
        addrs[0] = 32'd10; addrs[1] = 32'd11; addrs[2] = 32'd12; addrs[3] = 32'd13;
        idx    = 0;
        data_b = 1'b1;
        addr_d = addrs[0];
        addr_e = 1'b0;
        addr_v = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clock);
            acc = addr_v && !addr_b;
            if (acc) begin expQ.push_back('{data: expWord(addr_d), e: 1'b0}); idx++; end
            @(posedge clock); #1;
            if (acc) begin if (idx < 4) addr_d = addrs[idx]; else addr_v = 1'b0; end
        end
        vectors += 2;
        if (idx != 2) begin miscompares++; $display("[TB] FAIL bp_accepted got %0d required 2", idx); end
        if (addr_b !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_addr_b got %b required 1", addr_b); end
        data_b = 1'b0;
        base   = outCount;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clock);
            acc = addr_v && !addr_b;
            if (acc) begin expQ.push_back('{data: expWord(addr_d), e: 1'b0}); idx++; end
            @(posedge clock); #1;
            if (acc) begin if (idx < 4) addr_d = addrs[idx]; else addr_v = 1'b0; end
        end
        addr_v = 1'b0;
        vectors += 2;
        if (outCount - base != 4) begin miscompares++; $display("[TB] FAIL bp_release_tokens got %0d required 4", outCount - base); end
        if (idx != 4) begin miscompares++; $display("[TB] FAIL bp_total_accepted got %0d required 4", idx); end
        drainWait(10);
    endtask

    task automatic test_end();
        int w;
        data_b = 1'b0;
        applyStimulus(32'd3, 1'b0, w);
        applyStimulus(32'd7, 1'b0, w);
        applyStimulus(32'd0, 1'b1, w);
        repeat (4) @(posedge clock);
        #1;
        @(negedge clock);
        vectors += 2;
        if (expQ.size() != 0) begin miscompares++; $display("[TB] FAIL end_pending got %0d required 0", expQ.size()); end
        if (addr_b !== 1'b1) begin miscompares++; $display("[TB] FAIL done_addr_b got %b required 1", addr_b); end
        @(posedge clock); #1;
        addr_d = 32'd20;
        addr_v = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clock);
            vectors++;
            if (data_v !== 1'b0 || addr_b !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL done_quiet got v=%b b=%b required v=0 b=1", data_v, addr_b);
            end
            @(posedge clock); #1;
        end
        addr_v = 1'b0;
        reset  = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        expQ.delete();
    endtask

    task automatic test_range();
        int w;
        logic [7:0] wantD;
        logic       wantErr;
`ifdef SEGR_BOUNDS_CHECK_EN
        wantD   = 8'h00;
        wantErr = 1'b1;
`else
        wantD   = tblModel[44];
        wantErr = 1'b0;
`endif
        data_b = 1'b0;
        applyStimulus(32'd300, 1'b0, w);
        @(negedge clock);
        vectors += 2;
        if (data_v !== 1'b1 || data_d !== wantD) begin
            miscompares++;
            $display("[TB] FAIL range_data got v=%b d=%h required v=1 d=%h", data_v, data_d, wantD);
        end
        if (err !== wantErr) begin miscompares++; $display("[TB] FAIL range_err got %b required %b", err, wantErr); end
        @(posedge clock); #1;
        drainWait(10);
    endtask

    task automatic test_reset_midstream();
        int w;
        data_b = 1'b1;
        applyStimulus(32'd40, 1'b0, w);
        applyStimulus(32'd41, 1'b0, w);
        @(posedge clock); #1;
        @(negedge clock);
        vectors++;
        if (data_v !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_buffered got v=%b required 1", data_v); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        expQ.delete();
        @(negedge clock);
        vectors += 3;
        if (data_v !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_data_v got %b required 0", data_v); end
        if (addr_b !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_addr_b got %b required 0", addr_b); end
        if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_err got %b required 0", err); end
        @(posedge clock); #1;
        data_b = 1'b0;
        applyStimulus(32'd5, 1'b0, w);
        drainWait(10);
    endtask

    task automatic test_write_collision();
        int w;
        data_b    = 1'b0;
        addr_d    = 32'd9;
        addr_e    = 1'b0;
        addr_v    = 1'b1;
        init_we   = 1'b1;
        init_addr = 8'd9;
        init_data = 8'hEE;
        @(negedge clock);
        vectors++;
        if (addr_b !== 1'b0) begin miscompares++; $display("[TB] FAIL collide_addr_b got %b required 0", addr_b); end
        expQ.push_back('{data: tblModel[9], e: 1'b0});
        @(posedge clock); #1;
        init_we     = 1'b0;
        addr_v      = 1'b0;
        tblModel[9] = 8'hEE;
        drainWait(10);
        applyStimulus(32'd9, 1'b0, w);
        drainWait(10);
    endtask

    // Test sequence.
    initial begin
        $display("[TB] segment_r_responder bench start");
        test_reset();
        loadTable();
        test_basic();
        test_backpressure();
        test_end();
        test_range();
        test_reset_midstream();
        test_write_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/segment_r_responder.md
# segment_r_responder

Read-only segment responder: the memory side of a page's `segment_r_addr` / data stream pair. It consumes address tokens from the page's address output queue, reads a local synchronous table (e.g. a JPEG Huffman/ftab table), and returns one data token per address on the page's data input stream, in order. End-of-stream on the address stream is answered with end-of-stream on the data stream. It sits between a page's output queue and that page's data input queue.

## Interface
- `ADDR_W`, 32, address token width
- `DATA_W`, 8, data token width
- `DEPTH`, 256, table words; power of two, ≥2
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `addr_d`  in  ADDR_W  address token data
- `addr_e`  in  1  address token end-of-stream flag
- `addr_v`  in  1  address token valid
- `addr_b`  out  1  back-pressure to address producer
- `data_d`  out  DATA_W  returned table word
- `data_e`  out  1  returned end-of-stream flag
- `data_v`  out  1  returned token valid
- `data_b`  in  1  back-pressure from data consumer
- `init_we`  in  1  table write enable (load phase only)
- `init_addr`  in  log2(DEPTH)  table write index
- `init_data`  in  DATA_W  table write word
- `err`  out  1  sticky out-of-range flag

## Operation
- Transfer rule, both streams: a token moves in any cycle with `v=1` and `b=0`; otherwise the producer holds `d`, `e`, `v` stable.
- Table: DEPTH×DATA_W, synchronous write, synchronous 1-cycle read. Contents are not cleared by reset.
- Output buffer: 2-entry FIFO of {data, e}. `addr_b = 1` when occupied entries + in-flight read ≥ 2, and in DRAIN/DONE.
- FSM:
  - RUN: accept address tokens. Token with `addr_e=0` → issue table read. Token with `addr_e=1` → enqueue {0, e=1} (no table read, ordered after pending reads), go to DRAIN.
  - DRAIN: `addr_b=1`; when the e=1 token leaves the buffer → DONE.
  - DONE: `addr_b=1`, `data_v=0`; held until reset.
- Ordering: data tokens leave in address-acceptance order; exactly one data token per address token.
- `init_we` is honoured in any state; writing the index being read in the same cycle returns the old word.

## Timing
- Reset values: `addr_b=1` during reset, `0` in the first cycle after; `data_v=0`, `data_e=0`, `data_d=0`, `err=0`; FSM=RUN; buffer empty.
- Latency: address accepted in cycle N → `data_v=1` with the word in cycle N+1 if the buffer was empty.
- Throughput: 1 token/cycle sustained while `data_b=0`.
- Buffer full + `data_b=1`: `addr_b=1`; no token lost or duplicated. When `data_b` drops, one token leaves per cycle and `addr_b` deasserts in the same cycle the count falls below 2.
- Simultaneous enqueue and dequeue at full: count unchanged, `addr_b` stays 1.
- Reset mid-stream: buffer and in-flight read discarded; FSM returns to RUN; `err` cleared.

## Configuration
- `SEGR_BOUNDS_CHECK_EN` defined: an address ≥ DEPTH returns data 0 and sets `err` (sticky until reset). The stream still advances by one token.
- Not defined: the address is truncated to its low log2(DEPTH) bits, so the index wraps. `err` is tied to 0.

## Structure
- The shared package holds the state encoding (RUN/DRAIN/DONE), the buffer-entry struct {data, e}, and a `clog2` constant function.
- Sub-module `segr_out_fifo`: the 2-entry {data, e} FIFO with occupancy count. The top level holds the FSM, the table, and the bounds logic.

## Test plan
- Load table[i]=i^0x5A; send addresses 0,1,255 with `data_b=0` → data 0x5A,0x5B,0xA5, each one cycle after acceptance, back-to-back.
- Hold `data_b=1`, offer 4 addresses → exactly 2 accepted, `addr_b=1`. Release `data_b` → 4 tokens returned in order, no gaps beyond the 1-cycle read.
- Send addresses 3,7 then an `addr_e=1` token → data table[3], table[7], then `data_e=1`/`data_d=0`. `addr_b` stays 1 afterwards; a later `addr_v` pulse produces nothing.
- Address 300 with DEPTH=256: with the macro → data 0 and `err=1`. Without it → table[44] and `err=0`.
- Assert `reset=0` for 1 cycle while 2 tokens are buffered → `data_v=0` next cycle. The next address is served normally; table contents are retained.
- `init_we` to index 9 in the same cycle a read of 9 is accepted → old word returned; a following read of 9 → new word.
